regs_sb: RTL and testbench

- Parametrised successor to the picoMIPS register file.
- Provides DEPTH x N registers with register 0 hardwired to zero, two combinational read ports and one synchronous write port.
- Adds a per-register pending-write scoreboard with an outstanding-write counter and a flush.
- Sits between decode (read/issue) and writeback (write/clear). The pipeline uses the busy outputs to stall on RAW hazards.

---
 rtl/regs_pkg.sv | 17 +
 rtl/regs_sb_scoreboard.sv | 63 ++++++
 rtl/regs_sb.sv | 83 ++++++++
 tb/tb_regs_sb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// Shared types and helpers for the regs_sb register file.
// Optional same-cycle write bypass is enabled by defining REGS_BYPASS_EN.
package regs_pkg;

    // Address width needed to index a register file of the given depth
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned REGS_DEPTH_DEF = 32;
    localparam int unsigned REGS_A_DEF     = addr_width(REGS_DEPTH_DEF);

    typedef logic [REGS_A_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regs_sb_scoreboard.sv
// Pending-write scoreboard: one pending bit per register plus an incrementally
// maintained count of pending registers. Priority: flush, then issue, then clear.
module regs_sb_scoreboard
    import regs_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = 7,
    localparam int unsigned A    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             w,
    input  logic [A-1:0]     w_addr,
    input  logic             issue,
    input  logic [A-1:0]     issue_addr,
    input  logic             flush,
    output logic [DEPTH-1:0] pending,
    output logic [CNT_W-1:0] pend_cnt
);

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             issue_ok;
    logic             set_new;
    logic             clr_old;

    // Next pending vector and count; issue to the written register wins over the clear
    always_comb begin
        issue_ok = issue && (issue_addr != '0);
        set_new  = issue_ok && !pend_q[issue_addr];
        clr_old  = w && (w_addr != '0) && pend_q[w_addr] &&
                   !(issue_ok && (issue_addr == w_addr));
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        if (flush) begin
            pend_d = '0;
            cnt_d  = '0;
        end else begin
            if (clr_old) begin
                pend_d[w_addr] = 1'b0;
            end
            if (issue_ok) begin
                pend_d[issue_addr] = 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(set_new) - CNT_W'(clr_old);
        end
    end

    // Scoreboard state
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending  = pend_q;
    assign pend_cnt = cnt_q;

endmodule

// File: rtl/regs_sb.sv
// Register file with hardwired-zero r0, two combinational read ports, one
// synchronous write port and a pending-write scoreboard for RAW stalls.
// Define REGS_BYPASS_EN to forward same-cycle write data onto the read ports.
module regs_sb
    import regs_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = 7,
    localparam int unsigned A    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             w,
    input  logic [A-1:0]     w_addr,
    input  logic [N-1:0]     w_data,
    input  logic [A-1:0]     ra_addr,
    input  logic [A-1:0]     rb_addr,
    output logic [N-1:0]     ra_data,
    output logic [N-1:0]     rb_data,
    output logic             ra_busy,
    output logic             rb_busy,
    input  logic             issue,
    input  logic [A-1:0]     issue_addr,
    input  logic             flush,
    output logic [CNT_W-1:0] pend_cnt
);

    logic [N-1:0]     gpr_q [DEPTH];
    logic [DEPTH-1:0] pending;

    regs_sb_scoreboard #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk        (clk),
        .n_reset    (n_reset),
        .w          (w),
        .w_addr     (w_addr),
        .issue      (issue),
        .issue_addr (issue_addr),
        .flush      (flush),
        .pending    (pending),
        .pend_cnt   (pend_cnt)
    );

    // Register storage; r0 is never written so it stays zero
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (w && (w_addr != '0)) begin
            gpr_q[w_addr] <= w_data;
        end
    end

    // Read muxes and busy lookup, with optional same-cycle forwarding
    always_comb begin
        ra_data = gpr_q[ra_addr];
        rb_data = gpr_q[rb_addr];
        ra_busy = pending[ra_addr];
        rb_busy = pending[rb_addr];
`ifdef REGS_BYPASS_EN
        // Gated by reset so outputs stay zero while held in reset
        if (n_reset && w && (w_addr != '0)) begin
            if (w_addr == ra_addr) begin
                ra_data = w_data;
                if (!(issue && (issue_addr == ra_addr))) begin
                    ra_busy = 1'b0;
                end
            end
            if (w_addr == rb_addr) begin
                rb_data = w_data;
                if (!(issue && (issue_addr == rb_addr))) begin
                    rb_busy = 1'b0;
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_regs_sb.sv
// Self-checking bench for regs_sb against a behavioural register/scoreboard model.
module tb_regs_sb;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       w;
    logic [4:0] w_addr;
    logic [7:0] w_data;
    logic [4:0] ra_addr, rb_addr;
    logic [7:0] ra_data, rb_data;
    logic       ra_busy, rb_busy;
    logic       issue;
    logic [4:0] issue_addr;
    logic       flush;
    logic [6:0] pend_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model: register values and the set of pending registers
    logic [7:0] m_gpr [32];
    bit         m_pend [32];

    regs_sb dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .w          (w),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .ra_data    (ra_data),
        .rb_data    (rb_data),
        .ra_busy    (ra_busy),
        .rb_busy    (rb_busy),
        .issue      (issue),
        .issue_addr (issue_addr),
        .flush      (flush),
        .pend_cnt   (pend_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_gpr[i]  = 8'h00;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic logic [6:0] model_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return 7'(c);
    endfunction

    function automatic logic [7:0] exp_rd(input logic [4:0] a);
        logic [7:0] v = m_gpr[a];
`ifdef REGS_BYPASS_EN
        if (w && w_addr != 0 && w_addr == a) v = w_data;
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        logic b = m_pend[a];
`ifdef REGS_BYPASS_EN
        if (w && w_addr != 0 && w_addr == a && !(issue && issue_addr == a)) b = 1'b0;
`endif
        return b;
    endfunction

    // Apply the current inputs to the model, take one clock edge, then idle the controls
    task automatic tick();
        if (flush) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else begin
            if (w) m_pend[w_addr] = 1'b0;
            if (issue && issue_addr != 0) m_pend[issue_addr] = 1'b1;
        end
        if (w && w_addr != 0) m_gpr[w_addr] = w_data;
        @(posedge clk);
        #1;
        w     = 1'b0;
        issue = 1'b0;
        flush = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        n_reset    = 1'b0;
        ra_addr    = 5'($urandom_range(1, 31));
        rb_addr    = 5'($urandom_range(1, 31));
        w          = 1'b1;
        w_addr     = ra_addr;
        w_data     = 8'($urandom_range(1, 255));
        issue      = 1'b1;
        issue_addr = rb_addr;
        flush      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (ra_data !== 8'h00) begin errors++; $display("FAIL reset_ra_data got %h want 00", ra_data); end
        if (rb_data !== 8'h00) begin errors++; $display("FAIL reset_rb_data got %h want 00", rb_data); end
        if (ra_busy !== 1'b0) begin errors++; $display("FAIL reset_ra_busy got %b want 0", ra_busy); end
        if (rb_busy !== 1'b0) begin errors++; $display("FAIL reset_rb_busy got %b want 0", rb_busy); end
        if (pend_cnt !== 7'd0) begin errors++; $display("FAIL reset_pend_cnt got %0d want 0", pend_cnt); end
        @(negedge clk);
        w = 1'b0; issue = 1'b0;
        n_reset = 1'b1;
        ra_addr = 5'd5;
        tick();
        checks++;
        if (ra_data !== 8'h00) begin errors++; $display("FAIL post_reset_r5 got %h want 00", ra_data); end
    endtask

    task automatic test_write_read();
        w = 1'b1; w_addr = 5'd3; w_data = 8'hA5;
        tick();
        ra_addr = 5'd3; rb_addr = 5'd3;
        #1;
        checks += 2;
        if (ra_data !== 8'hA5) begin errors++; $display("FAIL wr_r3_a got %h want a5", ra_data); end
        if (rb_data !== 8'hA5) begin errors++; $display("FAIL wr_r3_b got %h want a5", rb_data); end
        w = 1'b1; w_addr = 5'd0; w_data = 8'hFF;
        tick();
        ra_addr = 5'd0;
        #1;
        checks++;
        if (ra_data !== 8'h00) begin errors++; $display("FAIL wr_r0 got %h want 00", ra_data); end
    endtask

    task automatic test_issue_clear();
        issue = 1'b1; issue_addr = 5'd7;
        tick();
        ra_addr = 5'd7;
        #1;
        checks += 2;
        if (ra_busy !== 1'b1) begin errors++; $display("FAIL issue_r7_busy got %b want 1", ra_busy); end
        if (pend_cnt !== 7'd1) begin errors++; $display("FAIL issue_r7_cnt got %0d want 1", pend_cnt); end
        w = 1'b1; w_addr = 5'd7; w_data = 8'h11;
        tick();
        checks += 3;
        if (ra_busy !== 1'b0) begin errors++; $display("FAIL clr_r7_busy got %b want 0", ra_busy); end
        if (pend_cnt !== 7'd0) begin errors++; $display("FAIL clr_r7_cnt got %0d want 0", pend_cnt); end
        if (ra_data !== 8'h11) begin errors++; $display("FAIL clr_r7_data got %h want 11", ra_data); end
        issue = 1'b1; issue_addr = 5'd0;
        tick();
        ra_addr = 5'd0;
        #1;
        checks += 2;
        if (ra_busy !== 1'b0) begin errors++; $display("FAIL issue_r0_busy got %b want 0", ra_busy); end
        if (pend_cnt !== 7'd0) begin errors++; $display("FAIL issue_r0_cnt got %0d want 0", pend_cnt); end
    endtask

    task automatic test_issue_write_same();
        issue = 1'b1; issue_addr = 5'd4;
        w = 1'b1; w_addr = 5'd4; w_data = 8'h22;
        tick();
        ra_addr = 5'd4;
        #1;
        checks += 3;
        if (ra_data !== 8'h22) begin errors++; $display("FAIL same_r4_data got %h want 22", ra_data); end
        if (ra_busy !== 1'b1) begin errors++; $display("FAIL same_r4_busy got %b want 1", ra_busy); end
        if (pend_cnt !== 7'd1) begin errors++; $display("FAIL same_r4_cnt got %0d want 1", pend_cnt); end
        issue = 1'b1; issue_addr = 5'd6;
        tick();
        issue = 1'b1; issue_addr = 5'd2;
        w = 1'b1; w_addr = 5'd6; w_data = 8'h66;
        tick();
        ra_addr = 5'd2; rb_addr = 5'd6;
        #1;
        checks += 3;
        if (pend_cnt !== 7'd2) begin errors++; $display("FAIL net0_cnt got %0d want 2", pend_cnt); end
        if (ra_busy !== 1'b1) begin errors++; $display("FAIL net0_r2_busy got %b want 1", ra_busy); end
        if (rb_busy !== 1'b0) begin errors++; $display("FAIL net0_r6_busy got %b want 0", rb_busy); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        for (int r = 1; r <= 3; r++) begin
            issue = 1'b1; issue_addr = 5'(r);
            tick();
        end
        checks++;
        if (pend_cnt !== 7'd3) begin errors++; $display("FAIL flush_pre_cnt got %0d want 3", pend_cnt); end
        flush = 1'b1; issue = 1'b1; issue_addr = 5'd9;
        tick();
        ra_addr = 5'd9; rb_addr = 5'd2;
        #1;
        checks += 3;
        if (pend_cnt !== 7'd0) begin errors++; $display("FAIL flush_cnt got %0d want 0", pend_cnt); end
        if (ra_busy !== 1'b0) begin errors++; $display("FAIL flush_r9_busy got %b want 0", ra_busy); end
        if (rb_busy !== 1'b0) begin errors++; $display("FAIL flush_r2_busy got %b want 0", rb_busy); end
    endtask

    task automatic test_bypass();
        logic [7:0] want;
        ra_addr = 5'd8;
        w = 1'b1; w_addr = 5'd8; w_data = 8'h3C;
        #1;
`ifdef REGS_BYPASS_EN
        want = 8'h3C;
`else
        want = 8'h00;
`endif
        checks++;
        if (ra_data !== want) begin errors++; $display("FAIL bypass_same got %h want %h", ra_data, want); end
        tick();
        checks++;
        if (ra_data !== 8'h3C) begin errors++; $display("FAIL bypass_next got %h want 3c", ra_data); end
    endtask

    task automatic test_random();
        logic [7:0] ea, eb;
        logic       ba, bb;
        for (int i = 0; i < 400; i++) begin
            w          = 1'($urandom_range(0, 1));
            w_addr     = 5'($urandom_range(0, 31));
            w_data     = 8'($urandom);
            issue      = ($urandom_range(0, 99) < 60);
            issue_addr = 5'($urandom_range(0, 31));
            flush      = ($urandom_range(0, 99) < 4);
            // Bias reads towards recently touched registers
            ra_addr    = ($urandom_range(0, 1) != 0) ? w_addr : 5'($urandom_range(0, 31));
            rb_addr    = ($urandom_range(0, 1) != 0) ? issue_addr : 5'($urandom_range(0, 31));
            #1;
            ea = exp_rd(ra_addr); eb = exp_rd(rb_addr);
            ba = exp_busy(ra_addr); bb = exp_busy(rb_addr);
            checks += 4;
            if (ra_data !== ea) begin errors++; $display("FAIL rnd_ra_data it %0d got %h want %h", i, ra_data, ea); end
            if (rb_data !== eb) begin errors++; $display("FAIL rnd_rb_data it %0d got %h want %h", i, rb_data, eb); end
            if (ra_busy !== ba) begin errors++; $display("FAIL rnd_ra_busy it %0d got %b want %b", i, ra_busy, ba); end
            if (rb_busy !== bb) begin errors++; $display("FAIL rnd_rb_busy it %0d got %b want %b", i, rb_busy, bb); end
            tick();
            checks++;
            if (pend_cnt !== model_cnt()) begin
                errors++;
                $display("FAIL rnd_pend_cnt it %0d got %0d want %0d", i, pend_cnt, model_cnt());
            end
        end
    endtask

    task automatic test_reset_mid();
        w = 1'b1; w_addr = 5'd12; w_data = 8'h5A;
        issue = 1'b1; issue_addr = 5'd13;
        tick();
        issue = 1'b1; issue_addr = 5'd14;
        w = 1'b1; w_addr = 5'd12; w_data = 8'h77;
        ra_addr = 5'd12; rb_addr = 5'd13;
        #1;
        n_reset = 1'b0;
        model_reset();
        #1;
        checks += 4;
        if (ra_data !== 8'h00) begin errors++; $display("FAIL midrst_ra_data got %h want 00", ra_data); end
        if (rb_busy !== 1'b0) begin errors++; $display("FAIL midrst_rb_busy got %b want 0", rb_busy); end
        if (pend_cnt !== 7'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", pend_cnt); end
        if (ra_busy !== 1'b0) begin errors++; $display("FAIL midrst_ra_busy got %b want 0", ra_busy); end
        @(negedge clk);
        w = 1'b0; issue = 1'b0;
        n_reset = 1'b1;
        ra_addr = 5'd12; rb_addr = 5'd14;
        tick();
        checks += 3;
        if (ra_data !== 8'h00) begin errors++; $display("FAIL midrst_r12 got %h want 00", ra_data); end
        if (rb_busy !== 1'b0) begin errors++; $display("FAIL midrst_r14_busy got %b want 0", rb_busy); end
        if (pend_cnt !== 7'd0) begin errors++; $display("FAIL midrst_cnt_after got %0d want 0", pend_cnt); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_issue_clear();
        test_issue_write_same();
        test_flush();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
